// File: rtl/picore_pkg.sv
// Shared definitions for the multi-channel PI controller: configuration-select
// encoding plus the saturating-add and output-clamp helpers.
package picore_pkg;

  // Working width for the helpers; wide enough for any practical ACCW or sum.
  localparam int XW = 128;

  typedef enum logic [1:0] {
    CFG_PCOEFF     = 2'd0,
    CFG_ICOEFF     = 2'd1,
    CFG_IN_OFFSET  = 2'd2,
    CFG_OUT_OFFSET = 2'd3
  } cfg_sel_e;

  typedef struct packed {
    logic signed [XW-1:0] val;
    logic                 ovf;
    logic                 unf;
  } clamp_t;

  // Signed add saturating symmetrically at +/-(2^(width-1)-1).
  function automatic logic signed [XW-1:0] sat_add(input logic signed [XW-1:0] a,
                                                   input logic signed [XW-1:0] b,
                                                   input int unsigned          width);
    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] lim;
    sum = a + b;
    lim = (XW'(1) << (width - 1)) - XW'(1);
    if (sum > lim)       sum = lim;
    else if (sum < -lim) sum = -lim;
    return sum;
  endfunction

  // Clamp to [lo, hi]; an inverted window resolves to hi.
  function automatic clamp_t clamp(input logic signed [XW-1:0] y,
                                   input logic signed [XW-1:0] lo,
                                   input logic signed [XW-1:0] hi);
    clamp_t r;
    r.ovf = (y > hi);
    r.unf = (y < lo);
    if (lo > hi || r.ovf) r.val = hi;
    else if (r.unf)       r.val = lo;
    else                  r.val = y;
    return r;
  endfunction

endpackage

// File: rtl/picore_cfg_regs.sv
// Per-channel coefficient and offset register file for picore_mc.
module picore_cfg_regs
  import picore_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int CW  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we_i,
  input  logic [$clog2(NCH)-1:0]    cfg_ch_i,
  input  logic [1:0]                cfg_sel_i,
  input  logic [CW-1:0]             cfg_data_i,
  output logic signed [CW-1:0]      pcoeff_o  [NCH],
  output logic signed [CW-1:0]      icoeff_o  [NCH],
  output logic [W-1:0]              in_off_o  [NCH],
  output logic [W-1:0]              out_off_o [NCH]
);

  logic signed [CW-1:0] pcoeff_q  [NCH];
  logic signed [CW-1:0] icoeff_q  [NCH];
  logic [W-1:0]         in_off_q  [NCH];
  logic [W-1:0]         out_off_q [NCH];

  // NOTE: this small register file is reset element by element because its
  // contents are defined after reset; large RAM-style arrays normally are not.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        pcoeff_q[k]  <= '0;
        icoeff_q[k]  <= '0;
        in_off_q[k]  <= '0;
        out_off_q[k] <= '0;
      end
    end else if (cfg_we_i) begin
      case (cfg_sel_i)
        CFG_PCOEFF:     pcoeff_q[cfg_ch_i]  <= cfg_data_i;
        CFG_ICOEFF:     icoeff_q[cfg_ch_i]  <= cfg_data_i;
        CFG_IN_OFFSET:  in_off_q[cfg_ch_i]  <= cfg_data_i[W-1:0];
        CFG_OUT_OFFSET: out_off_q[cfg_ch_i] <= cfg_data_i[W-1:0];
        default: ;
      endcase
    end
  end

  assign pcoeff_o  = pcoeff_q;
  assign icoeff_o  = icoeff_q;
  assign in_off_o  = in_off_q;
  assign out_off_o = out_off_q;

endmodule

// File: rtl/picore_mc.sv
// Time-multiplexed NCH-channel PI controller with a 4-stage pipeline.
// Optional anti-windup: define PICORE_MC_ANTIWINDUP_EN.
module picore_mc
  import picore_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int CW   = 32,
  parameter int FRAC = 16,
  parameter int ACCW = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclr,
  input  logic [NCH-1:0]         enable,
  input  logic                   update,
  input  logic [$clog2(NCH)-1:0] upd_ch,
  input  logic [W-1:0]           errorsig,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [1:0]             cfg_sel,
  input  logic [CW-1:0]          cfg_data,
  input  logic                   set_output_offset,
  input  logic                   set_output_clk,
  input  logic [W-1:0]           out_min,
  input  logic [W-1:0]           out_max,
  output logic [W-1:0]           regOut,
  output logic [$clog2(NCH)-1:0] regOutCh,
  output logic                   regOutUpdate,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CHW = $clog2(NCH);
  localparam int PW  = CW + W + 1;

  logic signed [CW-1:0] pcoeff  [NCH];
  logic signed [CW-1:0] icoeff  [NCH];
  logic [W-1:0]         in_off  [NCH];
  logic [W-1:0]         out_off [NCH];

  picore_cfg_regs #(.NCH(NCH), .W(W), .CW(CW)) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we_i  (cfg_we),
    .cfg_ch_i  (cfg_ch),
    .cfg_sel_i (cfg_sel),
    .cfg_data_i(cfg_data),
    .pcoeff_o  (pcoeff),
    .icoeff_o  (icoeff),
    .in_off_o  (in_off),
    .out_off_o (out_off)
  );

  // Stage 1: offset-corrected error.
  logic                 s1_vld_q;
  logic [CHW-1:0]       s1_ch_q;
  logic signed [W:0]    s1_e_q, s1_e_d;
  assign s1_e_d = $signed({1'b0, errorsig}) - $signed({1'b0, in_off[upd_ch]});

  // Stage 2: proportional and integral products.
  logic                 s2_vld_q;
  logic [CHW-1:0]       s2_ch_q;
  logic signed [PW-1:0] s2_p_q, s2_i_q, s2_p_d, s2_i_d;
  assign s2_p_d = $signed({{(W+1){pcoeff[s1_ch_q][CW-1]}}, pcoeff[s1_ch_q]})
                * $signed({{CW{s1_e_q[W]}}, s1_e_q});
  assign s2_i_d = $signed({{(W+1){icoeff[s1_ch_q][CW-1]}}, icoeff[s1_ch_q]})
                * $signed({{CW{s1_e_q[W]}}, s1_e_q});

  // Stage 3: integrator read-modify-write, preset and clear.
  logic                   s3_vld_q;
  logic [CHW-1:0]         s3_ch_q;
  logic signed [PW-1:0]   s3_p_q;
  logic signed [ACCW-1:0] s3_integ_q, s3_integ_d;
  logic signed [ACCW-1:0] integ_q [NCH];
  logic signed [ACCW-1:0] integ_d [NCH];
  logic signed [ACCW-1:0] preset_val;
  logic                   preset;
  logic                   commit;

`ifdef PICORE_MC_ANTIWINDUP_EN
  logic [NCH-1:0] ovf_last_q, unf_last_q;
`endif

  assign preset     = set_output_offset && set_output_clk;
  assign preset_val = ACCW'(out_off[cfg_ch]) << FRAC;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    integ_d    = integ_q;
    commit     = s2_vld_q;
    s3_integ_d = integ_q[s2_ch_q];
`ifdef PICORE_MC_ANTIWINDUP_EN
    if ((ovf_last_q[s2_ch_q] && !s2_i_q[PW-1] && (s2_i_q != '0)) ||
        (unf_last_q[s2_ch_q] && s2_i_q[PW-1]))
      commit = 1'b0;
`endif
    if (commit) begin
      s3_integ_d = ACCW'(sat_add(XW'(integ_q[s2_ch_q]), XW'(s2_i_q), ACCW));
      integ_d[s2_ch_q] = s3_integ_d;
    end
    if (preset) begin
      integ_d[cfg_ch] = preset_val;
      if (cfg_ch == s2_ch_q) s3_integ_d = preset_val;
    end
    if (sclr) begin
      for (int k = 0; k < NCH; k++) integ_d[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_e_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_ch_q    <= '0;
      s2_p_q     <= '0;
      s2_i_q     <= '0;
      s3_vld_q   <= 1'b0;
      s3_ch_q    <= '0;
      s3_p_q     <= '0;
      s3_integ_q <= '0;
      for (int k = 0; k < NCH; k++) integ_q[k] <= '0;
    end else begin
      s1_vld_q   <= !sclr && update && enable[upd_ch];
      s1_ch_q    <= upd_ch;
      s1_e_q     <= s1_e_d;
      s2_vld_q   <= !sclr && s1_vld_q;
      s2_ch_q    <= s1_ch_q;
      s2_p_q     <= s2_p_d;
      s2_i_q     <= s2_i_d;
      s3_vld_q   <= !sclr && s2_vld_q;
      s3_ch_q    <= s2_ch_q;
      s3_p_q     <= s2_p_q;
      s3_integ_q <= s3_integ_d;
      integ_q    <= integ_d;
    end
  end

  // Stage 4: scale, clamp and register the result.
  logic signed [XW-1:0] y;
  clamp_t               cl;
  assign y  = (XW'(s3_p_q) + XW'(s3_integ_q)) >>> FRAC;
  assign cl = clamp(y, $signed(XW'(out_min)), $signed(XW'(out_max)));

  logic [W-1:0]   regout_q;
  logic [CHW-1:0] regch_q;
  logic           regupd_q, ovf_q, unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regout_q <= '0;
      regch_q  <= '0;
      regupd_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      regupd_q <= !sclr && s3_vld_q;
      if (!sclr && s3_vld_q) begin
        regout_q <= W'(cl.val);
        regch_q  <= s3_ch_q;
        ovf_q    <= cl.ovf;
        unf_q    <= cl.unf;
      end
    end
  end

`ifdef PICORE_MC_ANTIWINDUP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_last_q <= '0;
      unf_last_q <= '0;
    end else if (sclr) begin
      ovf_last_q <= '0;
      unf_last_q <= '0;
    end else if (s3_vld_q) begin
      ovf_last_q[s3_ch_q] <= cl.ovf;
      unf_last_q[s3_ch_q] <= cl.unf;
    end
  end
`endif

  assign regOut       = regout_q;
  assign regOutCh     = regch_q;
  assign regOutUpdate = regupd_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_picore_mc.sv
// Directed self-checking bench for picore_mc (NCH=4, W=16, FRAC=16).
module tb_picore_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclr = 1'b0;
  logic [3:0]  enable = 4'hF;
  logic        update = 1'b0;
  logic [1:0]  upd_ch = '0;
  logic [15:0] errorsig = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        set_output_offset = 1'b0;
  logic        set_output_clk = 1'b0;
  logic [15:0] out_min = 16'h0000;
  logic [15:0] out_max = 16'hFFFF;
  logic [15:0] regOut;
  logic [1:0]  regOutCh;
  logic        regOutUpdate, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  picore_mc #(.NCH(4), .W(16), .CW(32), .FRAC(16), .ACCW(48)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .enable(enable), .update(update),
    .upd_ch(upd_ch), .errorsig(errorsig), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .set_output_offset(set_output_offset),
    .set_output_clk(set_output_clk), .out_min(out_min), .out_max(out_max),
    .regOut(regOut), .regOutCh(regOutCh), .regOutUpdate(regOutUpdate),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] err);
    upd_ch = ch; errorsig = err; update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Returns the number of ticks until a strobe is seen, or -1 after max ticks.
  task automatic wait_strobe(input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (regOutUpdate) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (regOut !== 16'h0) $display("FAIL reset_regOut: got %h exp 0000", regOut); else n_pass++;
    n_checks++; if (regOutCh !== 2'd0) $display("FAIL reset_regOutCh: got %0d exp 0", regOutCh); else n_pass++;
    n_checks++; if (regOutUpdate !== 1'b0) $display("FAIL reset_strobe: got %b exp 0", regOutUpdate); else n_pass++;
    n_checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {overflow, underflow}); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_proportional();
    cfg_write(2'd0, 2'd0, 32'h0001_0000);
    cfg_write(2'd0, 2'd2, 32'h0000_0100);
    send(2'd0, 16'h0250);
    tick(); tick();
    n_checks++; if (regOutUpdate !== 1'b0) $display("FAIL prop_early_strobe: got %b exp 0", regOutUpdate); else n_pass++;
    tick();
    n_checks++; if (regOutUpdate !== 1'b1) $display("FAIL prop_strobe: got %b exp 1", regOutUpdate); else n_pass++;
    n_checks++; if (regOut !== 16'h0150) $display("FAIL prop_regOut: got %h exp 0150", regOut); else n_pass++;
    n_checks++; if (regOutCh !== 2'd0) $display("FAIL prop_regOutCh: got %0d exp 0", regOutCh); else n_pass++;
    n_checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL prop_flags: got %b exp 00", {overflow, underflow}); else n_pass++;
    tick();
    n_checks++; if (regOutUpdate !== 1'b0) $display("FAIL prop_one_cycle: got %b exp 0", regOutUpdate); else n_pass++;
    n_checks++; if (regOut !== 16'h0150) $display("FAIL prop_hold: got %h exp 0150", regOut); else n_pass++;
  endtask

  task automatic test_integral();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0010; exp_v[1] = 16'h0020; exp_v[2] = 16'h0030;
    cfg_write(2'd1, 2'd1, 32'h0001_0000);
    upd_ch = 2'd1; errorsig = 16'h0010; update = 1'b1;
    tick(); tick(); tick();
    update = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (regOutUpdate !== 1'b1 || regOut !== exp_v[k] || regOutCh !== 2'd1)
        $display("FAIL integ_b2b_%0d: got upd=%b out=%h ch=%0d exp upd=1 out=%h ch=1", k, regOutUpdate, regOut, regOutCh, exp_v[k]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_preset();
    int lat;
    cfg_write(2'd2, 2'd3, 32'h0000_0600);
    set_output_offset = 1'b1; set_output_clk = 1'b1; cfg_ch = 2'd2;
    tick();
    set_output_clk = 1'b0; set_output_offset = 1'b0;
    send(2'd2, 16'h0000);
    wait_strobe(8, lat);
    n_checks++; if (lat != 3) $display("FAIL preset_latency: got %0d exp 3", lat); else n_pass++;
    n_checks++; if (regOut !== 16'h0600 || regOutCh !== 2'd2) $display("FAIL preset_regOut: got %h ch=%0d exp 0600 ch=2", regOut, regOutCh); else n_pass++;
  endtask

  task automatic test_back_to_back();
    upd_ch = 2'd0; errorsig = 16'h0300; update = 1'b1;
    tick();
    upd_ch = 2'd2; errorsig = 16'h0000;
    tick();
    update = 1'b0;
    tick(); tick();
    n_checks++; if (regOutUpdate !== 1'b1 || regOut !== 16'h0200 || regOutCh !== 2'd0)
      $display("FAIL b2b_first: got upd=%b out=%h ch=%0d exp upd=1 out=0200 ch=0", regOutUpdate, regOut, regOutCh);
    else n_pass++;
    tick();
    n_checks++; if (regOutUpdate !== 1'b1 || regOut !== 16'h0600 || regOutCh !== 2'd2)
      $display("FAIL b2b_second: got upd=%b out=%h ch=%0d exp upd=1 out=0600 ch=2", regOutUpdate, regOut, regOutCh);
    else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    int lat;
    logic [15:0] exp_third;
    out_max = 16'h1000;
    cfg_write(2'd3, 2'd0, 32'h0001_0000);
    cfg_write(2'd3, 2'd1, 32'h0001_0000);
    send(2'd3, 16'h2000);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h1000 || overflow !== 1'b1 || underflow !== 1'b0)
      $display("FAIL clamp_ovf: got lat=%0d out=%h ovf=%b unf=%b exp out=1000 ovf=1 unf=0", lat, regOut, overflow, underflow);
    else n_pass++;
    send(2'd3, 16'h2000);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h1000 || overflow !== 1'b1)
      $display("FAIL clamp_ovf2: got lat=%0d out=%h ovf=%b exp out=1000 ovf=1", lat, regOut, overflow);
    else n_pass++;
    // Read the integrator back through a pure-integral output.
    cfg_write(2'd3, 2'd0, 32'h0);
    cfg_write(2'd3, 2'd1, 32'h0);
    out_max = 16'hFFFF;
`ifdef PICORE_MC_ANTIWINDUP_EN
    exp_third = 16'h2000;
`else
    exp_third = 16'h4000;
`endif
    send(2'd3, 16'h0000);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== exp_third || overflow !== 1'b0)
      $display("FAIL clamp_integ: got lat=%0d out=%h ovf=%b exp out=%h ovf=0", lat, regOut, overflow, exp_third);
    else n_pass++;
    out_min = 16'h0100;
    send(2'd0, 16'h0050);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h0100 || overflow !== 1'b0 || underflow !== 1'b1)
      $display("FAIL clamp_unf: got lat=%0d out=%h ovf=%b unf=%b exp out=0100 ovf=0 unf=1", lat, regOut, overflow, underflow);
    else n_pass++;
    out_min = 16'h0200; out_max = 16'h0100;
    send(2'd0, 16'h0280);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h0100 || overflow !== 1'b1 || underflow !== 1'b1)
      $display("FAIL clamp_inverted: got lat=%0d out=%h ovf=%b unf=%b exp out=0100 ovf=1 unf=1", lat, regOut, overflow, underflow);
    else n_pass++;
    out_min = 16'h0000; out_max = 16'hFFFF;
  endtask

  task automatic test_sclr();
    int lat;
    send(2'd1, 16'h0010);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    wait_strobe(6, lat);
    n_checks++; if (lat != -1) $display("FAIL sclr_cancel: got strobe after %0d ticks exp none", lat); else n_pass++;
    send(2'd1, 16'h0010);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h0010) $display("FAIL sclr_integ1: got lat=%0d out=%h exp out=0010", lat, regOut); else n_pass++;
    send(2'd2, 16'h0000);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h0000) $display("FAIL sclr_integ2: got lat=%0d out=%h exp out=0000", lat, regOut); else n_pass++;
  endtask

  task automatic test_disabled();
    int lat;
    enable = 4'b1101;
    send(2'd1, 16'h0040);
    wait_strobe(8, lat);
    n_checks++; if (lat != -1) $display("FAIL disabled_drop: got strobe after %0d ticks exp none", lat); else n_pass++;
    enable = 4'hF;
  endtask

  task automatic test_reset_mid();
    int lat;
    send(2'd0, 16'h0250);
    wait_strobe(8, lat);
    n_checks++; if (lat < 0 || regOut !== 16'h0150) $display("FAIL rstmid_pre: got lat=%0d out=%h exp out=0150", lat, regOut); else n_pass++;
    send(2'd0, 16'h0250);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (regOut !== 16'h0 || regOutUpdate !== 1'b0 || regOutCh !== 2'd0 || overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL rstmid_async: got out=%h upd=%b ch=%0d ovf=%b unf=%b exp all 0", regOut, regOutUpdate, regOutCh, overflow, underflow);
    else n_pass++;
    tick();
    rst = 1'b0;
    wait_strobe(6, lat);
    n_checks++; if (lat != -1) $display("FAIL rstmid_no_strobe: got strobe after %0d ticks exp none", lat); else n_pass++;
    send(2'd0, 16'h0250);
    wait_strobe(8, lat);
    n_checks++; if (lat != 3 || regOut !== 16'h0000) $display("FAIL rstmid_coeff_cleared: got lat=%0d out=%h exp lat=3 out=0000", lat, regOut); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_preset();
    test_back_to_back();
    test_clamp();
    test_sclr();
    test_disabled();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picore_mc.md
PICORE_MC -- requirements
Module: picore_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of time-multiplexed PI channels (≥2).
REQ-002 The block SHALL have parameter W, default 16, giving the error, offset and output width.
REQ-003 The block SHALL have parameter CW, default 32, giving the signed coefficient width.
REQ-004 The block SHALL have parameter FRAC, default 16, giving the number of coefficient fraction bits.
REQ-005 The block SHALL have parameter ACCW, default 48, giving the signed integrator width.
REQ-006 The block SHALL have the following ports: clk (in, 1, sole clock); rst (in, 1, asynchronous active-high reset).
REQ-007 The block SHALL have ports sclr (in, 1, synchronous clear of all integrators); enable (in, NCH, per-channel run enable).
REQ-008 The block SHALL have ports update (in, 1, sample strobe); upd_ch (in, clog2(NCH), channel of the sample); errorsig (in, W, unsigned sample).
REQ-009 The block SHALL have ports cfg_we (in, 1); cfg_ch (in, clog2(NCH)); cfg_sel (in, 2: 0=pCoeff, 1=iCoeff, 2=inputOffset, 3=output_offset); cfg_data (in, CW).
REQ-010 The block SHALL have ports set_output_offset (in, 1, preset mode); set_output_clk (in, 1, preset strobe for cfg_ch).
REQ-011 The block SHALL have ports out_min, out_max (in, W, unsigned output clamp limits).
REQ-012 The block SHALL have ports regOut (out, W); regOutCh (out, clog2(NCH)); regOutUpdate (out, 1, one-cycle valid).
REQ-013 The block SHALL have ports overflow, underflow (out, 1, qualified by regOutUpdate).

Function
REQ-014 The cfg_we write SHALL update the selected per-channel register on the next clk edge (W-bit fields take cfg_data[W-1:0]).
REQ-015 An update with enable[upd_ch]=1 SHALL enter a 4-stage pipeline, and an update with enable[upd_ch]=0 SHALL be dropped without output.
REQ-016 The pipeline SHALL sustain one update per cycle, including back-to-back updates to the same channel (integrator read-modify-write completes within one stage, no hazard).
REQ-017 Stage 1 SHALL compute e = errorsig − inputOffset[ch], signed, W+1 bits.
REQ-018 Stage 2 SHALL compute p = pCoeff[ch]·e and i = iCoeff[ch]·e, each CW+W+1 bits signed.
REQ-019 Stage 3 SHALL compute integ[ch] += i, saturating at ±(2^(ACCW−1)−1) rather than wrapping.
REQ-020 Stage 4 SHALL compute y = (p + integ_new) >>> FRAC, arithmetic with truncation toward −inf.
REQ-021 Stage 4 SHALL clamp y to [out_min, out_max] and present it as regOut; overflow=1 if y>out_max, underflow=1 if y<out_min.
REQ-022 regOutUpdate SHALL assert exactly 4 cycles after the accepted update, with regOutCh equal to the sample's channel; regOut, regOutCh and the flags SHALL hold between strobes.
REQ-023 With set_output_offset=1, a set_output_clk pulse SHALL load integ[cfg_ch] = output_offset[cfg_ch] << FRAC.
REQ-024 If a preset and a stage-3 update hit the same channel in the same cycle, the preset SHALL win.
REQ-025 sclr SHALL zero all integrators and cancel in-flight pipeline entries (no regOutUpdate), and SHALL take precedence over update and preset.
REQ-026 If out_min > out_max, regOut SHALL equal out_max.

Reset
REQ-027 rst SHALL asynchronously clear all coefficients, offsets, integrators and pipeline valids to 0, and regOut, regOutCh, regOutUpdate, overflow and underflow to 0.
REQ-028 Reset SHALL apply mid-operation with immediate effect; no output strobe SHALL follow an update that was in flight when reset asserted.

Configuration
REQ-029 With PICORE_MC_ANTIWINDUP_EN defined, stage 3 SHALL not commit integ when the previous output of that channel was clamped and i has the same sign as the clamp direction (positive at overflow, negative at underflow).
REQ-030 Without PICORE_MC_ANTIWINDUP_EN, the integrator SHALL always commit, subject only to the REQ-019 saturation.

Structure
REQ-031 A shared package picore_pkg SHALL hold the cfg_sel encoding constants and the saturating add/clamp functions.
REQ-032 The per-channel coefficient/offset register file SHALL be a sub-module picore_cfg_regs.

Verification
REQ-033 Bench SHALL run with NCH=4, W=16, FRAC=16, out_min=0, out_max=0xFFFF unless stated, and cover the following directed scenarios.
REQ-034 Proportional: ch0 pCoeff=0x10000, iCoeff=0, inputOffset=0x100, errorsig=0x250 → regOut=0x150, regOutCh=0 exactly 4 cycles later.
REQ-035 Integral: ch1 iCoeff=0x10000, e=0x10, three back-to-back updates → regOut=0x10, 0x20, 0x30 on consecutive cycles.
REQ-036 Preset: ch2 output_offset=0x600, set_output_offset=1, set_output_clk pulse, coefficients 0, then update → regOut=0x600.
REQ-037 Clamp: out_max=0x1000, ch3 pCoeff=0x10000, e=0x2000 → regOut=0x1000, overflow=1; with iCoeff>0 and PICORE_MC_ANTIWINDUP_EN, integ[3] is unchanged on the next update.
REQ-038 Precedence: sclr asserted with update in flight → no regOutUpdate and all integrators 0; rst mid-stream → all outputs 0 immediately; disabled channel update → no strobe.
